alu_iterative: RTL
==================

Name: alu_iterative

Overview:
- Execution-side consumer of the 4-bit ALU Operation code produced by the ALU controller.
- Sits between decode and writeback in the multi-cycle datapath.
- Accepts operands and an operation through a valid/ready handshake.
- Non-shift operations complete in one cycle. SLLI/SRLI/SRAI use an iterative 1-bit-per-cycle shifter, which saves the barrel-shifter area.

Parameters:
- DATA_WIDTH, 32, operand and result width.
- SHAMT_WIDTH, $clog2(DATA_WIDTH) = 5, width of the shift-amount field taken from B.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand/operation request valid.
- in_ready  out  1  block can accept a request.
- Operation  in  4  ALU operation code.
- SrcA  in  DATA_WIDTH  operand A.
- SrcB  in  DATA_WIDTH  operand B; B[SHAMT_WIDTH-1:0] is the shift amount.
- flush  in  1  synchronous abort of the in-flight operation.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- ALUResult  out  DATA_WIDTH  registered result.
- Zero  out  1  registered, (ALUResult == 0).
- busy  out  1  high in SHIFT or DONE.

Behaviour:
- Operation map:
  - 0000 AND, 0001 OR, 0010 ADD, 0011 SUB, 0100 XOR.
  - 1000 BEQ, 1001 BNE, 1010 BLT, 1011 BGE.
  - 1100 SLLI, 1101 SRLI, 1110 SLT, 1111 SRAI.
  - 0101/0110/0111 are unused: result 0, single cycle.
- Branch/compare results: BEQ/BNE/BLT/BGE/SLT produce 1 in bit 0 when the condition is true, else 0. Upper bits are 0. BLT/BGE/SLT compare signed.
- ADD/SUB wrap modulo 2^DATA_WIDTH; no overflow flag.
- SRAI replicates A's MSB; SRLI shifts in 0.
- States: IDLE, SHIFT, DONE.
  - in_ready = (state == IDLE) && !flush.
  - out_valid = (state == DONE).
- IDLE, on accept (in_valid && in_ready at a rising edge):
  - Non-shift op, or shift with shamt == 0: register the result (for shamt 0, result = SrcA) and go to DONE.
  - Shift with shamt != 0: load the working register with SrcA, load the counter with shamt, latch the op, go to SHIFT.
- SHIFT: each edge shifts the working register by 1 and decrements the counter. On the edge where the counter == 1, the final shift is applied and the state goes to DONE.
- DONE:
  - ALUResult and Zero stay stable while out_valid && !out_ready.
  - When out_ready is high, go to IDLE.
  - No new request is accepted in DONE (no overlap).
- Latency, accept edge to out_valid high: 1 cycle for non-shift ops and shamt 0; 1 + shamt cycles for shamt ≥ 1. Worst case 32 cycles (shamt 31).
- Inputs are sampled only at accept; changes to SrcA/SrcB/Operation afterwards have no effect.
- flush high at an edge:
  - State goes to IDLE and any pending result is discarded.
  - ALUResult/Zero keep their old values, but out_valid drops.
  - flush has priority over accept, shift, and out_ready.
- Reset (asynchronous, mid-operation included):
  - state = IDLE, counter = 0, ALUResult = 0, Zero = 1.
  - out_valid = 0, busy = 0.
  - in_ready rises on the first edge after reset deassertion.
- ALUResult is only meaningful while out_valid is high.

Decomposition:
- Package alu_pkg:
  - alu_op_t enum with the 4-bit codes above (shared with the ALU controller).
  - state_t enum.
  - DATA_WIDTH default constant.
- Sub-module alu_comb: purely combinational logic for all single-cycle ops (logic, add/sub, compares). alu_iterative instantiates it and adds the FSM, counter and shift register.

Test Plan:
- ADD, SrcA=5, SrcB=0xFFFFFFFF, out_ready=1 → 1 cycle later out_valid=1, ALUResult=4, Zero=0. Then IDLE, in_ready=1.
- SRAI, SrcA=0x80000000, SrcB=4 → out_valid exactly 5 cycles after accept, ALUResult=0xF8000000, busy high throughout, in_ready low.
- SLLI, SrcA=1, shamt=0 → 1-cycle latency, ALUResult=1. SLLI shamt=31 → 32-cycle latency, ALUResult=0x80000000.
- BLT, SrcA=-1, SrcB=1 → ALUResult=1. BGE on the same operands → 0, Zero=1. BEQ 7,7 → 1.
- Backpressure: SUB, 3-3 with out_ready=0 for 4 cycles → out_valid, ALUResult=0, Zero=1 held stable. A request presented meanwhile is not accepted (in_ready=0). Result is consumed when out_ready=1.
- Abort: SRLI, shamt=20; flush at cycle 6 → IDLE next edge, out_valid never asserts. Repeat with reset asserted at cycle 6 → all outputs at reset values immediately. A new ADD after release completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU datapath.
//   alu_op_t : 4-bit ALU operation code (also produced by the ALU controller)
//   state_t  : alu_iterative sequencer states
//   DEFAULT_DATA_WIDTH : default operand/result width
package alu_pkg;

   localparam int DEFAULT_DATA_WIDTH = 32;

   typedef enum logic [3:0] {
      OP_AND  = 4'b0000,
      OP_OR   = 4'b0001,
      OP_ADD  = 4'b0010,
      OP_SUB  = 4'b0011,
      OP_XOR  = 4'b0100,
      OP_BEQ  = 4'b1000,
      OP_BNE  = 4'b1001,
      OP_BLT  = 4'b1010,
      OP_BGE  = 4'b1011,
      OP_SLLI = 4'b1100,
      OP_SRLI = 4'b1101,
      OP_SLT  = 4'b1110,
      OP_SRAI = 4'b1111
   } alu_op_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_DONE
   } state_t;

   function automatic logic is_shift(input alu_op_t op);
      return (op == OP_SLLI) || (op == OP_SRLI) || (op == OP_SRAI);
   endfunction

endpackage

// File: rtl/alu_comb.sv
// Single-cycle ALU operations: logic, add/sub, compares.
//   op : operation code
//   a  : operand A
//   b  : operand B
//   y  : result; compares give 0/1 in bit 0, shift ops pass A through
//        (shifting is done iteratively by the parent), unused codes give 0.
module alu_comb
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
   input  alu_op_t               op,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   output logic [DATA_WIDTH-1:0] y
);

   always_comb begin
      y = '0;
      case (op)
         OP_AND:  y = a & b;
         OP_OR:   y = a | b;
         OP_ADD:  y = a + b;
         OP_SUB:  y = a - b;
         OP_XOR:  y = a ^ b;
         OP_BEQ:  y[0] = (a == b);
         OP_BNE:  y[0] = (a != b);
         OP_BLT:  y[0] = ($signed(a) <  $signed(b));
         OP_BGE:  y[0] = ($signed(a) >= $signed(b));
         OP_SLT:  y[0] = ($signed(a) <  $signed(b));
         // a zero-distance shift completes here with A unchanged
         OP_SLLI,
         OP_SRLI,
         OP_SRAI: y = a;
         default: y = '0;
      endcase
   end

endmodule

// File: rtl/alu_iterative.sv
// Multi-cycle ALU: single-cycle ops via alu_comb, SLLI/SRLI/SRAI via a
// 1-bit-per-cycle shifter.
//   clk, reset          : clock, async active-low reset
//   in_valid/in_ready   : request handshake (Operation, SrcA, SrcB)
//   flush               : synchronous abort, beats every other action
//   out_valid/out_ready : result handshake (ALUResult, Zero)
//   busy                : operation in flight (SHIFT or DONE)
module alu_iterative
   import alu_pkg::*;
#(
   parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
   parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [3:0]            Operation,
   input  logic [DATA_WIDTH-1:0] SrcA,
   input  logic [DATA_WIDTH-1:0] SrcB,
   input  logic                  flush,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] ALUResult,
   output logic                  Zero,
   output logic                  busy
);

   state_t                 state;
   alu_op_t                op_q;
   logic [SHAMT_WIDTH-1:0] cnt;
   logic [DATA_WIDTH-1:0]  wreg;
   logic                   started;

   alu_op_t                op_in;
   logic [SHAMT_WIDTH-1:0] shamt;
   logic [DATA_WIDTH-1:0]  comb_y;
   logic [DATA_WIDTH-1:0]  shifted;
   logic                   accept;

   assign op_in = alu_op_t'(Operation);
   assign shamt = SrcB[SHAMT_WIDTH-1:0];

   // held low until the first edge after reset release
   assign in_ready  = started && (state == S_IDLE) && !flush;
   assign accept    = in_valid && in_ready;
   assign out_valid = (state == S_DONE);
   assign busy      = (state != S_IDLE);

   alu_comb #(.DATA_WIDTH(DATA_WIDTH)) u_comb (
      .op (op_in),
      .a  (SrcA),
      .b  (SrcB),
      .y  (comb_y)
   );

   // one-bit step of the latched shift
   always_comb begin
      shifted = wreg;
      case (op_q)
         OP_SLLI: shifted = {wreg[DATA_WIDTH-2:0], 1'b0};
         OP_SRLI: shifted = {1'b0, wreg[DATA_WIDTH-1:1]};
         OP_SRAI: shifted = {wreg[DATA_WIDTH-1], wreg[DATA_WIDTH-1:1]};
         default: shifted = wreg;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= S_IDLE;
         op_q      <= OP_AND;
         cnt       <= '0;
         wreg      <= '0;
         ALUResult <= '0;
         Zero      <= 1'b1;
         started   <= 1'b0;
      end else begin
         started <= 1'b1;
         if (flush) begin
            // abandon work; output registers keep their last values
            state <= S_IDLE;
            cnt   <= '0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (accept) begin
                     if (is_shift(op_in) && (shamt != '0)) begin
                        wreg  <= SrcA;
                        cnt   <= shamt;
                        op_q  <= op_in;
                        state <= S_SHIFT;
                     end else begin
                        ALUResult <= comb_y;
                        Zero      <= (comb_y == '0);
                        state     <= S_DONE;
                     end
                  end
               end
               S_SHIFT: begin
                  wreg <= shifted;
                  cnt  <= cnt - 1'b1;
                  if (cnt == SHAMT_WIDTH'(1)) begin
                     ALUResult <= shifted;
                     Zero      <= (shifted == '0);
                     state     <= S_DONE;
                  end
               end
               S_DONE: begin
                  if (out_ready) state <= S_IDLE;
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule
